// File: rtl/mul_pkg.sv
// Shared definitions for the NMul multiplier and its prod_accum downstream stage.
// Keeps operand-width defaults and the accumulator state encoding in one place.
package mul_pkg;

  localparam int NSIZE_DEF = 2;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  // Width needed to hold a product count in the range 0..count.
  function automatic int cw_f(input int count);
    return $clog2(count + 1);
  endfunction

endpackage

// File: rtl/prod_accum_sat_add.sv
// Unsigned W-bit saturating adder: clamps to all-ones and flags the carry-out.
// Purely combinational, no latency, no flow control.
module sat_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_carry
);

  logic [W:0] w_raw;

  assign w_raw   = {1'b0, i_a} + {1'b0, i_b};
  assign o_carry = w_raw[W];
  assign o_sum   = w_raw[W] ? {W{1'b1}} : w_raw[W-1:0];

endmodule

// File: rtl/prod_accum.sv
// Sums Count unsigned products per block with saturation; a block result appears one edge after its last product/Flush.
// While a result waits for Out_ready, In_ready stays low and upstream stalls.
module prod_accum
  import mul_pkg::*;
#(
  parameter int Nsize = NSIZE_DEF,
  parameter int Rsize = 2 * Nsize,
  parameter int Asize = 2 * Nsize + 4,
  parameter int Count = 8,
  parameter int Cw    = cw_f(Count)
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [Rsize-1:0] R,
  input  logic             Flush,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [Asize-1:0] Sum,
  output logic [Cw-1:0]    Nout,
  output logic             Ovf
);

  state_t r_state;
  state_t w_state_nxt;

  logic [Asize-1:0] r_acc;
  logic [Cw-1:0]    r_cnt;
  logic             r_ovf;

  logic [Asize-1:0] w_r_ext;
  logic [Asize-1:0] w_add_sum;
  logic             w_add_carry;
  logic             w_take;
  logic             w_end;
  logic [Asize-1:0] w_acc_nxt;
  logic [Cw-1:0]    w_cnt_nxt;
  logic             w_ovf_nxt;

  always_comb begin
    w_r_ext            = '0;
    w_r_ext[Rsize-1:0] = R;
  end

  sat_add #(
    .W(Asize)
  ) u_sat_add (
    .i_a    (r_acc),
    .i_b    (w_r_ext),
    .o_sum  (w_add_sum),
    .o_carry(w_add_carry)
  );

  assign w_take    = (r_state == ACC) && In_valid;
  assign w_acc_nxt = w_take ? w_add_sum : r_acc;
  assign w_cnt_nxt = w_take ? (r_cnt + Cw'(1)) : r_cnt;
  assign w_ovf_nxt = r_ovf | (w_take & w_add_carry);
  // A same-cycle product is folded in before a Flush closes the block.
  assign w_end     = (r_state == ACC) &&
                     ((w_take && (w_cnt_nxt == Cw'(Count))) || Flush);

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      r_state <= ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACC:     if (w_end)     w_state_nxt = DONE;
      DONE:    if (Out_ready) w_state_nxt = ACC;
      default:                w_state_nxt = ACC;
    endcase
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      Sum   <= '0;
      Nout  <= '0;
      Ovf   <= 1'b0;
    end else if (w_end) begin
      Sum   <= w_acc_nxt;
      Nout  <= w_cnt_nxt;
      Ovf   <= w_ovf_nxt;
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_take) begin
      r_acc <= w_acc_nxt;
      r_cnt <= w_cnt_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  // Handshake outputs are straight decodes of the state flop.
  assign In_ready  = (r_state == ACC);
  assign Out_valid = (r_state == DONE);

endmodule

// File: tb/tb_prod_accum.sv
module tb_prod_accum;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Clr;
  logic       iv[3];
  logic [3:0] rr[3];
  logic       fl[3];
  logic       ordy[3];
  logic       ir[3];
  logic       ov[3];
  logic       ovf[3];

  logic [7:0] sum_a, sum_c;
  logic [4:0] sum_b;
  logic [2:0] nout_a;
  logic [3:0] nout_b, nout_c;
  logic [7:0] sum_w[3];
  logic [3:0] nout_w[3];

  assign sum_w[0]  = sum_a;
  assign sum_w[1]  = {3'b000, sum_b};
  assign sum_w[2]  = sum_c;
  assign nout_w[0] = {1'b0, nout_a};
  assign nout_w[1] = nout_b;
  assign nout_w[2] = nout_c;

  prod_accum #(.Nsize(2), .Count(4)) u_a (
    .Clk(Clk), .Clr(Clr), .In_valid(iv[0]), .In_ready(ir[0]), .R(rr[0]),
    .Flush(fl[0]), .Out_valid(ov[0]), .Out_ready(ordy[0]),
    .Sum(sum_a), .Nout(nout_a), .Ovf(ovf[0]));

  prod_accum #(.Nsize(2), .Asize(5), .Count(8)) u_b (
    .Clk(Clk), .Clr(Clr), .In_valid(iv[1]), .In_ready(ir[1]), .R(rr[1]),
    .Flush(fl[1]), .Out_valid(ov[1]), .Out_ready(ordy[1]),
    .Sum(sum_b), .Nout(nout_b), .Ovf(ovf[1]));

  prod_accum #(.Nsize(2), .Count(9)) u_c (
    .Clk(Clk), .Clr(Clr), .In_valid(iv[2]), .In_ready(ir[2]), .R(rr[2]),
    .Flush(fl[2]), .Out_valid(ov[2]), .Out_ready(ordy[2]),
    .Sum(sum_c), .Nout(nout_c), .Ovf(ovf[2]));

  // Reference: each block is a list of accepted products; result is min(total, max).
  int CNT[3]  = '{4, 8, 9};
  int MAXV[3] = '{255, 31, 255};
  int tot[3], cnt[3], e_sum[3], e_n[3];
  bit pend[3], e_ovf[3];
  bit nv[3], nf[3], no[3];
  int nr[3];
  int n_cmp = 0, n_bad = 0;

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      tot[k] = 0; cnt[k] = 0; pend[k] = 0;
      e_sum[k] = 0; e_n[k] = 0; e_ovf[k] = 0;
    end
  endtask

  task automatic idle_next();
    for (int k = 0; k < 3; k++) begin
      nv[k] = 0; nr[k] = 0; nf[k] = 0; no[k] = 1;
    end
  endtask

  // One clock: drive the staged inputs, advance the reference, compare every instance.
  task automatic tick();
    @(negedge Clk);
    for (int k = 0; k < 3; k++) begin
      iv[k] = nv[k]; rr[k] = 4'(nr[k]); fl[k] = nf[k]; ordy[k] = no[k];
      if (!pend[k]) begin
        if (nv[k]) begin
          tot[k] += nr[k];
          cnt[k] += 1;
        end
        if ((nv[k] && cnt[k] == CNT[k]) || nf[k]) begin
          pend[k]  = 1;
          e_sum[k] = (tot[k] > MAXV[k]) ? MAXV[k] : tot[k];
          e_n[k]   = cnt[k];
          e_ovf[k] = (tot[k] > MAXV[k]);
          tot[k] = 0; cnt[k] = 0;
        end
      end else if (no[k]) begin
        pend[k] = 0;
      end
    end
    @(posedge Clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp += 5;
      if (ov[k] !== pend[k]) begin
        n_bad++; $display("FAIL out_valid[%0d] got %b want %b", k, ov[k], pend[k]);
      end
      if (ir[k] !== !pend[k]) begin
        n_bad++; $display("FAIL in_ready[%0d] got %b want %b", k, ir[k], !pend[k]);
      end
      if (sum_w[k] !== 8'(e_sum[k])) begin
        n_bad++; $display("FAIL sum[%0d] got %0d want %0d", k, sum_w[k], e_sum[k]);
      end
      if (nout_w[k] !== 4'(e_n[k])) begin
        n_bad++; $display("FAIL nout[%0d] got %0d want %0d", k, nout_w[k], e_n[k]);
      end
      if (ovf[k] !== e_ovf[k]) begin
        n_bad++; $display("FAIL ovf[%0d] got %b want %b", k, ovf[k], e_ovf[k]);
      end
    end
    idle_next();
  endtask

  task automatic test_reset();
    Clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 0; rr[k] = 0; fl[k] = 0; ordy[k] = 1;
    end
    idle_next();
    model_clear();
    #12;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (ov[k] !== 1'b0 || ir[k] !== 1'b1 || sum_w[k] !== 8'd0 ||
          nout_w[k] !== 4'd0 || ovf[k] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset[%0d] got ov=%b ir=%b sum=%0d n=%0d ovf=%b want 0 1 0 0 0",
                 k, ov[k], ir[k], sum_w[k], nout_w[k], ovf[k]);
      end
    end
    @(negedge Clk);
    Clr = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int seq[4] = '{1, 4, 9, 3};
    for (int i = 0; i < 4; i++) begin
      nv[0] = 1; nr[0] = seq[i];
      tick();
    end
    n_cmp++;
    if (ov[0] !== 1'b1 || sum_a !== 8'd17 || nout_a !== 3'd4 || ovf[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_block got ov=%b sum=%0d n=%0d ovf=%b want 1 17 4 0",
               ov[0], sum_a, nout_a, ovf[0]);
    end
    tick();
    n_cmp++;
    if (ov[0] !== 1'b0) begin
      n_bad++; $display("FAIL basic_one_cycle got ov=%b want 0", ov[0]);
    end
  endtask

  task automatic test_flush();
    nv[0] = 1; nr[0] = 9; tick();
    nv[0] = 1; nr[0] = 9; tick();
    nv[0] = 1; nr[0] = 2; nf[0] = 1; tick();
    n_cmp++;
    if (ov[0] !== 1'b1 || sum_a !== 8'd20 || nout_a !== 3'd3) begin
      n_bad++;
      $display("FAIL flush_block got ov=%b sum=%0d n=%0d want 1 20 3", ov[0], sum_a, nout_a);
    end
    tick();
    nf[0] = 1; tick();
    n_cmp++;
    if (ov[0] !== 1'b1 || sum_a !== 8'd0 || nout_a !== 3'd0 || ovf[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_empty got ov=%b sum=%0d n=%0d ovf=%b want 1 0 0 0",
               ov[0], sum_a, nout_a, ovf[0]);
    end
    tick();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 4; i++) begin
      nv[1] = 1; nr[1] = 9; tick();
    end
    nf[1] = 1; tick();
    n_cmp++;
    if (ov[1] !== 1'b1 || sum_b !== 5'd31 || ovf[1] !== 1'b1 || nout_b !== 4'd4) begin
      n_bad++;
      $display("FAIL sat_block got ov=%b sum=%0d ovf=%b n=%0d want 1 31 1 4",
               ov[1], sum_b, ovf[1], nout_b);
    end
    tick();
    nv[1] = 1; nr[1] = 1; tick();
    nv[1] = 1; nr[1] = 2; nf[1] = 1; tick();
    n_cmp++;
    if (sum_b !== 5'd3 || ovf[1] !== 1'b0) begin
      n_bad++; $display("FAIL sat_next got sum=%0d ovf=%b want 3 0", sum_b, ovf[1]);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    int post;
    for (int i = 0; i < 4; i++) begin
      nv[0] = 1; nr[0] = i + 2; no[0] = 0; tick();
    end
    held = sum_a;
    for (int i = 0; i < 5; i++) begin
      nv[0] = 1; nr[0] = $urandom_range(1, 9); nf[0] = i[0]; no[0] = 0;
      tick();
      n_cmp++;
      if (ir[0] !== 1'b0 || sum_a !== held || ov[0] !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_hold got ir=%b ov=%b sum=%0d want 0 1 %0d", ir[0], ov[0], sum_a, held);
      end
    end
    nv[0] = 1; nr[0] = 7; no[0] = 1; tick();
    post = 0;
    for (int i = 0; i < 4; i++) begin
      nv[0] = 1; nr[0] = i + 1; post += i + 1; tick();
    end
    n_cmp++;
    if (sum_a !== 8'(post) || nout_a !== 3'd4) begin
      n_bad++; $display("FAIL bp_after got sum=%0d n=%0d want %0d 4", sum_a, nout_a, post);
    end
    tick();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      nv[0] = 1; nr[0] = 5; tick();
    end
    #2;
    Clr = 1'b0;
    #1;
    n_cmp++;
    if (sum_a !== 8'd0 || nout_a !== 3'd0 || ovf[0] !== 1'b0 || ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL async_clr got sum=%0d n=%0d ovf=%b ov=%b ir=%b want 0 0 0 0 1",
               sum_a, nout_a, ovf[0], ov[0], ir[0]);
    end
    model_clear();
    tick();
    @(negedge Clk);
    Clr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nv[0] = 1; nr[0] = 1; tick();
    end
    n_cmp++;
    if (sum_a !== 8'd4 || nout_a !== 3'd4 || ov[0] !== 1'b1) begin
      n_bad++; $display("FAIL async_after got sum=%0d n=%0d ov=%b want 4 4 1", sum_a, nout_a, ov[0]);
    end
    tick();
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      for (int k = 0; k < 3; k++) begin
        nv[k] = ($urandom_range(0, 3) != 0);
        nr[k] = $urandom_range(0, 3) * $urandom_range(0, 3);
        nf[k] = ($urandom_range(0, 11) == 0);
        no[k] = ($urandom_range(0, 3) != 0);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_end_to_end();
    for (int a = 1; a <= 3; a++) begin
      for (int b = 1; b <= 3; b++) begin
        nv[2] = 1; nr[2] = a * b; tick();
      end
    end
    n_cmp++;
    if (ov[2] !== 1'b1 || sum_c !== 8'd36 || nout_c !== 4'd9) begin
      n_bad++; $display("FAIL e2e got ov=%b sum=%0d n=%0d want 1 36 9", ov[2], sum_c, nout_c);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flush();
    test_saturate();
    test_backpressure();
    test_async_reset();
    test_end_to_end();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prod_accum.md
# prod_accum

- Downstream stage of the N-bit × N-bit multiplier `NMul`.
- Consumes its 2·Nsize-bit products `R` through a valid/ready handshake and sums `Count` products per block in a saturating accumulator.
- Presents each block's sum, product count and overflow flag through an output valid/ready handshake.
- Serves as the accumulate half of a multiply-accumulate path built on the multiplier.

## Interface
- `Nsize`, 2, multiplier operand width.
- `Rsize`, 2*Nsize, product width; must equal the multiplier's `R` width.
- `Asize`, 2*Nsize+4, accumulator / `Sum` width; must be ≥ Rsize.
- `Count`, 8, products per block; ≥ 1.
- `Cw`, $clog2(Count+1), width of `Nout`.

Ports:
- `Clk`  in  1  single clock; all state changes on its rising edge.
- `Clr`  in  1  reset, asynchronous, active-low.
- `In_valid`  in  1  product `R` is valid this cycle.
- `In_ready`  out  1  block can accept a product.
- `R`  in  Rsize  unsigned product from the multiplier.
- `Flush`  in  1  end the current block early.
- `Out_valid`  out  1  `Sum`/`Nout`/`Ovf` hold a completed block.
- `Out_ready`  in  1  consumer takes the block.
- `Sum`  out  Asize  block sum, saturated.
- `Nout`  out  Cw  number of products in the block.
- `Ovf`  out  1  saturation occurred in this block.

## Operation
- Two states:
  - ACC: `In_ready`=1, `Out_valid`=0.
  - DONE: `In_ready`=0, `Out_valid`=1.
- Reset (`Clr`=0, takes effect immediately):
  - state = ACC.
  - Internal accumulator and counter = 0.
  - `Sum`=0, `Nout`=0, `Ovf`=0, `Out_valid`=0, `In_ready`=1 (driven from state, 1 while in ACC).
- ACC, product accepted (`In_valid`=1):
  - acc ← sat(acc + zero-extended R); cnt ← cnt+1.
  - Sticky `ovf` ← 1 if the unsaturated sum exceeds 2^Asize−1.
  - sat() clamps to all-ones.
- Block ends when either:
  - an accepted product makes cnt = Count, or
  - `Flush`=1 in ACC.
- Flush with an accepted product in the same cycle: the product is included in the block.
- On block end:
  - `Sum` ← final acc (including the same-cycle product), `Nout` ← final cnt, `Ovf` ← final ovf.
  - Internal acc, cnt and ovf are cleared; state → DONE.
- Flush in ACC with cnt=0 and no product: emits an empty block (`Sum`=0, `Nout`=0, `Ovf`=0).
- DONE:
  - `Sum`/`Nout`/`Ovf` stay stable.
  - `In_valid` and `Flush` are ignored; no product is lost, because `In_ready`=0.
  - `Out_ready`=1 → ACC next cycle.
  - `Sum`/`Nout`/`Ovf` keep their last values after leaving DONE and are only meaningful while `Out_valid`=1.
- Products are unsigned; no sign extension.

## Timing
- All outputs are registered; `In_ready` depends only on state, never combinationally on inputs.
- Latency: `Out_valid` rises on the edge after the cycle in which the final product or `Flush` was sampled.
- Throughput:
  - one product per cycle in ACC;
  - one bubble cycle per block (the DONE cycle) when `Out_ready` is held at 1.
- `Out_ready` held at 0: DONE persists indefinitely; the upstream multiplier must stall (no products are accepted).
- Reset mid-block or in DONE discards the partial or pending block; no output is produced for it.
- Count = 1: every accepted product ends a block.

## Structure
- Shared package `mul_pkg` holds:
  - state enum {ACC, DONE};
  - a width helper for `Cw`;
  - default `Nsize`, so the multiplier and this block share the same defaults.
- One natural sub-module, `sat_add`: a parameterised Asize-bit unsigned saturating adder with a carry-out flag.

## Test plan
- Nsize=2, Count=4, `Out_ready`=1; feed R=1,4,9,3 on consecutive cycles → one block: `Sum`=17, `Nout`=4, `Ovf`=0; `Out_valid` high for exactly 1 cycle, starting the cycle after R=3 is accepted.
- Feed R=9,9, then `Flush`=1 together with R=2 → `Sum`=20, `Nout`=3; a following `Flush` with no input → `Sum`=0, `Nout`=0.
- Asize=5, Count=8; feed R=9 ×4 → `Sum`=31 (saturated), `Ovf`=1; the next block starts with `Ovf`=0.
- Backpressure: hold `Out_ready`=0 for 5 cycles after a block completes while `In_valid`=1 → `In_ready`=0 throughout, outputs stable, the next block's sum counts only products accepted after the release.
- Drive `Clr`=0 asynchronously, mid-clock, after 2 of 4 products → outputs zero before the next edge; after release, 4 products R=1 → `Sum`=4, `Nout`=4.
- End-to-end: connect to `NMul` (Nsize=2), sweep A,B over 1..3, Count=9 → `Sum`=36.
